ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the L1 core: owns the architectural fetch PC and issues word fetches to instruction memory over a valid/ready request and response channel. It buffers returned instructions with their PCs in a small FIFO for decode. It is the consumer of the execute stage's redirect pair (jump enable, jump PC): a redirect flushes all buffered and in-flight fetches and restarts fetch at the new PC.

## Interface
- `ADDR_W`, default `` `ADDR_WIDTH`` (32): PC / fetch address width.
- `INST_W`, default `` `DATA_WIDTH`` (32): instruction word width.
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.
- `DEPTH`, default 2: fetch FIFO entries; power of two, ≥2.

Ports:
- `i_clk` in 1: clock. Only clock; all state on rising edge.
- `i_rst` in 1: reset. Asynchronous, active-high.
- `i_exu_jmp_en` in 1: redirect request from execute.
- `i_exu_jmp_pc` in ADDR_W: redirect target; bits [1:0] forced to 0.
- `o_ifu_req_valid` out 1: fetch request valid.
- `i_ifu_req_ready` in 1: memory accepts request.
- `o_ifu_req_addr` out ADDR_W: fetch address, word aligned.
- `i_ifu_rsp_valid` in 1: memory returns instruction (no backpressure).
- `i_ifu_rsp_data` in INST_W: returned instruction.
- `o_sys_valid` out 1: FIFO head valid toward decode.
- `i_sys_ready` in 1: decode consumes head.
- `o_ifu_pc` out ADDR_W: PC of head entry; 0 when `o_sys_valid`=0.
- `o_ifu_inst` out INST_W: head instruction; 0 when `o_sys_valid`=0.

## Operation
- State machine states: IDLE, REQ, WAIT, DROP. Only one request outstanding at a time.
- IDLE: entered on reset. Moves to REQ on the first clock edge after reset deasserts.
- REQ: `o_ifu_req_valid`=1 only while FIFO count < DEPTH. Otherwise it waits in REQ with valid low.
  - Request is accepted when valid and ready are both high. `fetch_pc` += 4 (modulo 2^ADDR_W), then go to WAIT.
- WAIT: on `i_ifu_rsp_valid`, push {address of the request, data} into the FIFO, then go to REQ.
  - Space is guaranteed because issue required count < DEPTH and only one request is outstanding.
- DROP: a discarded request is outstanding. On `i_ifu_rsp_valid`, discard the data and go to REQ.
- Redirect (`i_exu_jmp_en`=1) has top priority in any state:
  - flush the FIFO (count=0); set `fetch_pc` = {jmp_pc[ADDR_W-1:2], 2'b00}.
  - Next state:
    - DROP if a request is outstanding, i.e. state is WAIT or DROP with no response this cycle, or state is REQ with the request accepted this cycle;
    - otherwise REQ.
  - Redirect in WAIT/DROP coinciding with `i_ifu_rsp_valid`: the response is discarded and the next state is REQ.
  - Redirect in REQ without accept: the pending request is withdrawn. Address changes next cycle; the memory side tolerates withdrawal.
- Redirect and pop in the same cycle: the pop completes (decode took the entry) and the flush still clears the rest.
- Pop and push in the same cycle: count is unchanged. FIFO uses wrap-around pointers.
- Request stability: once `o_ifu_req_valid`=1, address and valid are held until accepted, except on redirect.

## Timing
- During and immediately after reset: `o_ifu_req_valid`=0, `o_ifu_req_addr`=RESET_PC, `o_sys_valid`=0, `o_ifu_pc`=0, `o_ifu_inst`=0.
- First request is presented in cycle 1 after reset release.
- Redirect sampled at edge N: request with the new address is presented from cycle N+1. No instruction from before the redirect is visible after edge N.
- Response at edge k: `o_sys_valid`=1 from cycle k+1 (registered FIFO).
- Peak throughput is one instruction per 2 cycles with a single-cycle memory.
- All outputs are driven from registers, except the `IFU_BYPASS_EN` path.

## Configuration
- `IFU_BYPASS_EN` defined: when the FIFO is empty and `i_ifu_rsp_valid` arrives in WAIT without a redirect, the response is driven combinationally on `o_sys_valid`/`o_ifu_pc`/`o_ifu_inst`.
  - If `i_sys_ready`=1 that cycle, the entry is consumed and not pushed.
  - Otherwise it is pushed as normal.
  - Latency from response to decode is 0 cycles.
- Undefined: all instructions pass through the FIFO, with 1-cycle latency; no combinational path from memory to decode.

## Test plan
- Reset, memory always ready with 1-cycle response, decode ready: request addresses are 0x80000000, 0x80000004, 0x80000008 in order. Each `o_ifu_pc` matches its request address and `o_ifu_inst` equals the returned data.
- `i_sys_ready`=0 held: exactly DEPTH=2 instructions are buffered, then `o_ifu_req_valid` stays 0. Releasing ready drains 0x80000000, then 0x80000004, and fetch resumes at 0x80000008.
- Redirect to 0x80000103 while in WAIT: the returned response is dropped, the next request address is 0x80000100, the FIFO is empty the next cycle, and the next `o_ifu_pc`=0x80000100.
- Redirect coinciding with `i_ifu_rsp_valid` and with a decode pop: the popped entry is counted as consumed once, the response is not delivered, and no DROP state occurs. The next request goes to the target PC.
- `i_ifu_req_ready` held low for 5 cycles: valid stays 1 and the address stays constant. Async `i_rst` asserted mid-WAIT: outputs return to reset values immediately, and a late response is ignored after reset release.
- With `IFU_BYPASS_EN`, FIFO empty and decode ready: `o_sys_valid`=1 in the same cycle as `i_ifu_rsp_valid`, carrying the same data.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one word fetch at a time and buffers {pc, inst} for decode.
// Optional IFU_BYPASS_EN adds a combinational memory-to-decode path when the buffer is empty.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ifu_fetch #(
  parameter int                ADDR_W   = `ADDR_WIDTH,
  parameter int                INST_W   = `DATA_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000),
  parameter int                DEPTH    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_exu_jmp_en,
  input  logic [ADDR_W-1:0] i_exu_jmp_pc,
  output logic              o_ifu_req_valid,
  input  logic              i_ifu_req_ready,
  output logic [ADDR_W-1:0] o_ifu_req_addr,
  input  logic              i_ifu_rsp_valid,
  input  logic [INST_W-1:0] i_ifu_rsp_data,
  output logic              o_sys_valid,
  input  logic              i_sys_ready,
  output logic [ADDR_W-1:0] o_ifu_pc,
  output logic [INST_W-1:0] o_ifu_inst
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] jmp_tgt;
  logic              req_vld;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic accept, rsp_take, fifo_vld, push, pop;

  assign jmp_tgt  = i_exu_jmp_pc & ~ADDR_W'(3);
  assign accept   = (state == REQ) && req_vld && i_ifu_req_ready;
  assign rsp_take = (state == WAIT) && i_ifu_rsp_valid && !i_exu_jmp_en;
  assign fifo_vld = (count != '0);
  assign pop      = fifo_vld && i_sys_ready;

  assign o_ifu_req_valid = req_vld;
  assign o_ifu_req_addr  = fetch_pc;

`ifdef IFU_BYPASS_EN
  logic byp_hit;

  // An empty buffer lets the response reach decode in the same cycle; it is
  // only stored if decode does not take it right away.
  assign byp_hit     = rsp_take && !fifo_vld;
  assign push        = rsp_take && !(byp_hit && i_sys_ready);
  assign o_sys_valid = fifo_vld || byp_hit;
  assign o_ifu_pc    = fifo_vld ? pc_mem[rd_ptr]   : (byp_hit ? req_pc         : '0);
  assign o_ifu_inst  = fifo_vld ? inst_mem[rd_ptr] : (byp_hit ? i_ifu_rsp_data : '0);
`else
  assign push        = rsp_take;
  assign o_sys_valid = fifo_vld;
  assign o_ifu_pc    = fifo_vld ? pc_mem[rd_ptr]   : '0;
  assign o_ifu_inst  = fifo_vld ? inst_mem[rd_ptr] : '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (accept) state_nxt = i_exu_jmp_en ? DROP : WAIT;
      end
      WAIT: begin
        if (i_ifu_rsp_valid)   state_nxt = REQ;
        else if (i_exu_jmp_en) state_nxt = DROP;
      end
      DROP: begin
        if (i_ifu_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (i_exu_jmp_en) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_vld  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      // Registered request valid: issue only when the buffer has room for the reply.
      req_vld <= (state_nxt == REQ) && (count_nxt < CNT_W'(DEPTH));
      if (i_exu_jmp_en)
        fetch_pc <= jmp_tgt;
      else if (accept)
        fetch_pc <= fetch_pc + ADDR_W'(4);
      if (i_exu_jmp_en) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) req_pc <= fetch_pc;
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= i_ifu_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a latency-configurable memory model plus a {pc, inst} scoreboard queue.
// Honours IFU_BYPASS_EN for the expected response-to-decode latency.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IFU_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_exu_jmp_en = 1'b0;
  logic [31:0] i_exu_jmp_pc = '0;
  logic        o_ifu_req_valid;
  logic        i_ifu_req_ready = 1'b1;
  logic [31:0] o_ifu_req_addr;
  logic        i_ifu_rsp_valid = 1'b0;
  logic [31:0] i_ifu_rsp_data = '0;
  logic        o_sys_valid;
  logic        i_sys_ready = 1'b1;
  logic [31:0] o_ifu_pc;
  logic [31:0] o_ifu_inst;

  ifu_fetch dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_exu_jmp_en    (i_exu_jmp_en),
    .i_exu_jmp_pc    (i_exu_jmp_pc),
    .o_ifu_req_valid (o_ifu_req_valid),
    .i_ifu_req_ready (i_ifu_req_ready),
    .o_ifu_req_addr  (o_ifu_req_addr),
    .i_ifu_rsp_valid (i_ifu_rsp_valid),
    .i_ifu_rsp_data  (i_ifu_rsp_data),
    .o_sys_valid     (o_sys_valid),
    .i_sys_ready     (i_sys_ready),
    .o_ifu_pc        (o_ifu_pc),
    .o_ifu_inst      (o_ifu_inst)
  );

  always #5 i_clk = ~i_clk;

  ent_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          pend_active = 0;
  int          pend_wait = 0;
  logic [31:0] pend_addr = '0;
  bit          pend_stale = 0;
  bit          rsp_stale = 0;
  logic [31:0] rsp_addr = '0;
  int          mem_lat = 1;
  bit          last_acc = 0;
  int          pop_cnt = 0;
  logic [31:0] last_pop_pc = '0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/check at the falling edge, advance the memory model after the rising edge.
  task automatic tick();
    logic acc;
    ent_t e;
    @(negedge i_clk);
    acc = o_ifu_req_valid && i_ifu_req_ready && !i_rst;
    last_acc = acc;
    if (acc) chk("req_addr", o_ifu_req_addr, exp_pc);
    if (i_ifu_rsp_valid && !rsp_stale && !i_exu_jmp_en && !i_rst) begin
      chk("rsp_latency", o_sys_valid, (q.size() == 0) ? BYP : 1'b1);
      q.push_back({rsp_addr, i_ifu_rsp_data});
    end
    if (!o_sys_valid) begin
      chk("idle_pc_zero", o_ifu_pc, 0);
      chk("idle_inst_zero", o_ifu_inst, 0);
    end
    if (o_sys_valid && i_sys_ready) begin
      chk("pop_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pop_pc", o_ifu_pc, e.pc);
        chk("pop_inst", o_ifu_inst, e.inst);
        last_pop_pc = o_ifu_pc;
        pop_cnt++;
      end
    end
    if (i_exu_jmp_en) begin
      q.delete();
      if (pend_active) pend_stale = 1;
    end
    if (acc) begin
      pend_active = 1;
      pend_wait   = mem_lat - 1;
      pend_addr   = o_ifu_req_addr;
      pend_stale  = i_exu_jmp_en;
    end
    if (i_exu_jmp_en) exp_pc = i_exu_jmp_pc & ~32'd3;
    else if (acc)     exp_pc = exp_pc + 32'd4;
    @(posedge i_clk);
    #1;
    i_ifu_rsp_valid = 1'b0;
    rsp_stale = 0;
    if (pend_active) begin
      if (pend_wait == 0) begin
        i_ifu_rsp_valid = 1'b1;
        i_ifu_rsp_data  = mdata(pend_addr);
        rsp_addr        = pend_addr;
        rsp_stale       = pend_stale;
        pend_active     = 0;
      end else begin
        pend_wait--;
      end
    end
  endtask

  task automatic wait_acc_q1(input string tag, input int lim);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      if (last_acc && q.size() == 1) ok = 1;
    end
    chk({tag, "_timeout"}, ok, 1);
  endtask

  task automatic wait_pop(input string tag, input int lim);
    int p0 = pop_cnt;
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      if (pop_cnt != p0) ok = 1;
    end
    chk({tag, "_timeout"}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] head0, held_addr;
    int p0;
    bit ok;

    // Reset values
    repeat (3) tick();
    chk("rst_req_valid", o_ifu_req_valid, 0);
    chk("rst_req_addr", o_ifu_req_addr, RESET_PC);
    chk("rst_sys_valid", o_sys_valid, 0);
    i_rst = 1'b0;
    chk("post_rst_req_valid", o_ifu_req_valid, 0);
    tick();
    chk("first_req_valid", o_ifu_req_valid, 1);
    chk("first_req_addr", o_ifu_req_addr, RESET_PC);

    // Streaming with single-cycle memory
    repeat (12) tick();
    chk("stream_pops", pop_cnt >= 3, 1);

    // Decode stalled: buffer fills, requests stop
    i_sys_ready = 1'b0;
    repeat (10) tick();
    chk("full_req_valid", o_ifu_req_valid, 0);
    chk("full_sys_valid", o_sys_valid, 1);
    head0 = (q.size() != 0) ? q[0].pc : 32'hDEAD_BEEF;
    chk("full_head_pc", o_ifu_pc, head0);
    repeat (3) tick();
    chk("full_req_valid_hold", o_ifu_req_valid, 0);
    i_sys_ready = 1'b1;
    tick();
    chk("drain_first", last_pop_pc, head0);
    tick();
    chk("drain_second", last_pop_pc, head0 + 32'd4);
    repeat (4) tick();

    // Redirect while a fetch is outstanding
    i_sys_ready = 1'b0;
    mem_lat = 2;
    wait_acc_q1("redir_wait_setup", 40);
    i_exu_jmp_en = 1'b1;
    i_exu_jmp_pc = 32'h8000_0103;
    tick();
    i_exu_jmp_en = 1'b0;
    chk("redir_flush", o_sys_valid, 0);
    chk("redir_drop_valid", o_ifu_req_valid, 0);
    chk("redir_addr", o_ifu_req_addr, 32'h8000_0100);
    i_sys_ready = 1'b1;
    wait_pop("redir_pop", 20);
    chk("redir_first_pc", last_pop_pc, 32'h8000_0100);

    // Redirect coinciding with a response and a pop
    i_sys_ready = 1'b0;
    mem_lat = 2;
    wait_acc_q1("redir_rsp_setup", 40);
    tick();
    i_exu_jmp_en = 1'b1;
    i_exu_jmp_pc = 32'h8000_0200;
    i_sys_ready = 1'b1;
    p0 = pop_cnt;
    tick();
    i_exu_jmp_en = 1'b0;
    chk("redir_rsp_pop_once", pop_cnt - p0, 1);
    chk("redir_rsp_flush", o_sys_valid, 0);
    chk("redir_rsp_no_drop", o_ifu_req_valid, 1);
    chk("redir_rsp_addr", o_ifu_req_addr, 32'h8000_0200);
    mem_lat = 1;
    wait_pop("redir_rsp_pop", 20);
    chk("redir_rsp_first_pc", last_pop_pc, 32'h8000_0200);

    // Memory not ready: request held stable
    i_ifu_req_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (o_ifu_req_valid) ok = 1;
    end
    chk("stall_valid_timeout", ok, 1);
    held_addr = o_ifu_req_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", o_ifu_req_valid, 1);
      chk("stall_addr", o_ifu_req_addr, held_addr);
    end
    i_ifu_req_ready = 1'b1;
    repeat (4) tick();

    // Asynchronous reset mid-WAIT, then a late response
    i_sys_ready = 1'b0;
    mem_lat = 3;
    wait_acc_q1("arst_setup", 40);
    tick();
    i_rst = 1'b1;
    #1;
    chk("arst_req_valid", o_ifu_req_valid, 0);
    chk("arst_req_addr", o_ifu_req_addr, RESET_PC);
    chk("arst_sys_valid", o_sys_valid, 0);
    chk("arst_pc", o_ifu_pc, 0);
    chk("arst_inst", o_ifu_inst, 0);
    pend_active = 0;
    q.delete();
    exp_pc = RESET_PC;
    mem_lat = 1;
    i_ifu_req_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    i_ifu_rsp_valid = 1'b1;
    i_ifu_rsp_data = 32'h0BAD_0BAD;
    rsp_stale = 1;
    tick();
    i_ifu_rsp_valid = 1'b1;
    i_ifu_rsp_data = 32'h0BAD_0BAD;
    rsp_stale = 1;
    tick();
    chk("late_rsp_ignored", o_sys_valid, 0);
    i_ifu_req_ready = 1'b1;
    i_sys_ready = 1'b1;
    wait_pop("arst_pop", 20);
    chk("arst_first_pc", last_pop_pc, RESET_PC);

    // Drain
    repeat (6) tick();
    i_ifu_req_ready = 1'b0;
    repeat (6) tick();
    chk("drain_empty", o_sys_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
